// File: rtl/tetris_vga_render.sv
// tetris_vga_render: 640x480@60 VGA renderer for the Tetris playfield.
//
// Takes a copy of the game grid and score once per frame, during vertical blank.
// From that copy it draws the 10x20 playfield with 16-pixel cells, a 4-pixel border
// and a 16-square binary score bar. The pixel rate is derived from the 100 MHz gm_clk.
//
// Ports:
//   gm_clk        system clock; all logic runs on it
//   gm_rst        synchronous active-high reset
//   grid          [row][col] 4-bit colour codes, row 0 at the top
//   score         16-bit score, MSB drawn leftmost
//   vga_r/g/b     4-bit colour channels
//   vga_hs/vs     active-low syncs, aligned with the colour outputs
//   frame_start   one-cycle pulse on the snapshot cycle (h==0, v==480)
module tetris_vga_render #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PF_X    = 240,
    parameter int unsigned PF_Y    = 80
) (
    input  logic                   gm_clk,
    input  logic                   gm_rst,
    input  logic [19:0][9:0][3:0]  grid,
    input  logic [15:0]            score,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   frame_start
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    localparam logic [9:0] HLast     = 10'd799;
    localparam logic [9:0] VLast     = 10'd524;
    localparam logic [9:0] HVis      = 10'd640;
    localparam logic [9:0] VVis      = 10'd480;
    localparam logic [9:0] HSyncBeg  = 10'd656;
    localparam logic [9:0] HSyncEnd  = 10'd751;
    localparam logic [9:0] VSyncBeg  = 10'd490;
    localparam logic [9:0] VSyncEnd  = 10'd491;
    localparam logic [9:0] SnapLine  = 10'd480;

    localparam logic [9:0] PfX0  = 10'(PF_X);
    localparam logic [9:0] PfX1  = 10'(PF_X + 160);
    localparam logic [9:0] PfY0  = 10'(PF_Y);
    localparam logic [9:0] PfY1  = 10'(PF_Y + 320);
    localparam logic [9:0] BrdX0 = 10'(PF_X - 4);
    localparam logic [9:0] BrdX1 = 10'(PF_X + 164);
    localparam logic [9:0] BrdY0 = 10'(PF_Y - 4);
    localparam logic [9:0] BrdY1 = 10'(PF_Y + 324);
    localparam logic [9:0] BarY0 = 10'd56;
    localparam logic [9:0] BarY1 = 10'd63;

    typedef enum logic [2:0] {
        ClsBlank,
        ClsBg,
        ClsBorder,
        ClsScoreOn,
        ClsScoreOff,
        ClsCell
    } cls_e;

    // Pixel enable and raster counters
    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic            pix_en;
    logic            snap;

    assign pix_en = (div_q == DivLast);
    assign snap   = pix_en && (h_q == 10'd0) && (v_q == SnapLine);

    always_comb begin
        div_d = div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_en) begin
            div_d = '0;
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge gm_clk) begin
        if (gm_rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Shadow copies: rendering never reads the live inputs, so a frame cannot tear
    logic [19:0][9:0][3:0] shadow_q;
    logic [15:0]           score_sh_q;

    always_ff @(posedge gm_clk) begin
        if (gm_rst) begin
            shadow_q   <= '0;
            score_sh_q <= '0;
        end else if (snap) begin
            shadow_q   <= grid;
            score_sh_q <= score;
        end
    end

    assign frame_start = snap;

    // Stage 1: classify the pixel at (h_q, v_q)
    logic [7:0] sx;
    logic [8:0] sy;
    logic [3:0] bar_k;
    logic [7:0] bar_lx;
    logic       in_x, in_y, in_brd, in_bar_row;
    cls_e       cls_q, cls_d;
    logic [3:0] code_q, code_d;
    logic       gap_q, gap_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;

    // Offsets are only meaningful inside the playfield columns/rows they are used for
    assign sx     = 8'(h_q - PfX0);
    assign sy     = 9'(v_q - PfY0);
    assign bar_k  = 4'(sx / 8'd10);
    assign bar_lx = sx % 8'd10;

    assign in_x       = (h_q >= PfX0) && (h_q < PfX1);
    assign in_y       = (v_q >= PfY0) && (v_q < PfY1);
    assign in_brd     = (h_q >= BrdX0) && (h_q < BrdX1) && (v_q >= BrdY0) && (v_q < BrdY1);
    assign in_bar_row = (v_q >= BarY0) && (v_q <= BarY1);

    always_comb begin
        cls_d  = ClsBg;
        code_d = 4'd0;
        gap_d  = 1'b0;
        hs1_d  = !((h_q >= HSyncBeg) && (h_q <= HSyncEnd));
        vs1_d  = !((v_q >= VSyncBeg) && (v_q <= VSyncEnd));
        if ((h_q >= HVis) || (v_q >= VVis)) begin
            cls_d = ClsBlank;
        end else if (in_x && in_y) begin
            cls_d  = ClsCell;
            code_d = shadow_q[sy[8:4]][sx[7:4]];
            gap_d  = (sx[3:0] == 4'hF) || (sy[3:0] == 4'hF);
        end else if (in_brd) begin
            cls_d = ClsBorder;
        end else if (in_bar_row && in_x && (bar_lx < 8'd8)) begin
            // Square k shows bit 15-k so the MSB is leftmost
            cls_d = score_sh_q[4'd15 - bar_k] ? ClsScoreOn : ClsScoreOff;
        end
    end

    always_ff @(posedge gm_clk) begin
        if (gm_rst) begin
            cls_q  <= ClsBlank;
            code_q <= 4'd0;
            gap_q  <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
        end else if (pix_en) begin
            cls_q  <= cls_d;
            code_q <= code_d;
            gap_q  <= gap_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
        end
    end

    // Stage 2: class to colour; syncs ride along one more stage to stay aligned
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q;

    always_comb begin
        rgb_d = 12'h000;
        case (cls_q)
            ClsBorder:   rgb_d = 12'hFFF;
            ClsScoreOn:  rgb_d = 12'hFFF;
            ClsScoreOff: rgb_d = 12'h333;
            ClsCell: begin
                if (!gap_q) begin
                    case (code_q)
                        4'd0:    rgb_d = 12'h000;
                        4'd1:    rgb_d = 12'h0FF;
                        4'd2:    rgb_d = 12'hFF0;
                        4'd3:    rgb_d = 12'hA0F;
                        4'd4:    rgb_d = 12'hF80;
                        4'd5:    rgb_d = 12'h00F;
                        4'd6:    rgb_d = 12'h0F0;
                        4'd7:    rgb_d = 12'hF00;
                        default: rgb_d = 12'h888;
                    endcase
                end
            end
            default: rgb_d = 12'h000;
        endcase
    end

    always_ff @(posedge gm_clk) begin
        if (gm_rst) begin
            rgb_q <= 12'h000;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else if (pix_en) begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];
    assign vga_hs = hs2_q;
    assign vga_vs = vs2_q;

endmodule

// File: tb/tb_tetris_vga_render.sv
// tb_tetris_vga_render: directed, table-driven bench for tetris_vga_render.
// A full frame is 1.68M cycles, so the bench repositions the raster counters
// directly to reach the snapshot line and the pixels of interest.
module tb_tetris_vga_render;

    logic                  gm_clk = 1'b0;
    logic                  gm_rst;
    logic [19:0][9:0][3:0] grid;
    logic [15:0]           score;
    logic [3:0]            vga_r, vga_g, vga_b;
    logic                  vga_hs, vga_vs, frame_start;

    tetris_vga_render dut (
        .gm_clk      (gm_clk),
        .gm_rst      (gm_rst),
        .grid        (grid),
        .score       (score),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    always #5 gm_clk = ~gm_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int h, input int v, input logic [11:0] rgb,
                                input logic hs, input logic vs);
        vec_t t;
        t.h = h; t.v = v; t.rgb = rgb; t.hs = hs; t.vs = vs;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Place the raster at (h, v) with a fresh divider phase
    task automatic jump(input int h, input int v);
        @(negedge gm_clk);
        dut.div_q <= '0;
        dut.h_q   <= 10'(h);
        dut.v_q   <= 10'(v);
    endtask

    // Outputs for (h, v) appear two pixel periods (8 cycles) after the counters hold it
    task automatic render(input int h, input int v, output logic [11:0] rgb,
                          output logic hs, output logic vs);
        jump(h, v);
        repeat (8) @(posedge gm_clk);
        @(negedge gm_clk);
        rgb = {vga_r, vga_g, vga_b};
        hs  = vga_hs;
        vs  = vga_vs;
    endtask

    task automatic check_pix(input string name, input int h, input int v,
                             input logic [11:0] exp);
        logic [11:0] rgb;
        logic        hs, vs;
        render(h, v, rgb, hs, vs);
        check(name, int'(rgb), int'(exp));
    endtask

    // Pass through h==0, v==480 and check the one-cycle frame_start pulse
    task automatic do_snapshot();
        jump(0, 480);
        repeat (3) @(posedge gm_clk);
        @(negedge gm_clk);
        check("fs_high", int'(frame_start), 1);
        @(posedge gm_clk);
        @(negedge gm_clk);
        check("fs_low_after", int'(frame_start), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"}, int'(vga_hs), 1);
        check({tag, "_vs"}, int'(vga_vs), 1);
        check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
    endtask

    initial begin
        logic [11:0] rgb;
        logic        hs, vs;
        int          k;

        gm_rst = 1'b1;
        grid   = '0;
        score  = 16'h0000;
        repeat (3) @(posedge gm_clk);
        @(negedge gm_clk);
        check_reset_outputs("por");
        gm_rst = 1'b0;

        // Before any snapshot the playfield is empty even with a populated grid input
        grid[0][0]  = 4'd7;
        grid[1][0]  = 4'd1;
        grid[1][1]  = 4'd4;
        grid[1][2]  = 4'd5;
        grid[1][3]  = 4'd6;
        grid[5][3]  = 4'd3;
        grid[10][9] = 4'd12;
        grid[19][9] = 4'd2;
        score       = 16'h8001;
        check_pix("pre_snap_cell", 240, 80, 12'h000);
        check_pix("pre_snap_bar", 240, 56, 12'h333);
        do_snapshot();

        vecs.push_back(mk(240, 80, 12'hF00, 1'b1, 1'b1));   // cell code 7
        vecs.push_back(mk(255, 80, 12'h000, 1'b1, 1'b1));   // gap column
        vecs.push_back(mk(240, 95, 12'h000, 1'b1, 1'b1));   // gap row
        vecs.push_back(mk(256, 80, 12'h000, 1'b1, 1'b1));   // empty cell
        vecs.push_back(mk(240, 96, 12'h0FF, 1'b1, 1'b1));   // code 1
        vecs.push_back(mk(256, 96, 12'hF80, 1'b1, 1'b1));   // code 4
        vecs.push_back(mk(272, 96, 12'h00F, 1'b1, 1'b1));   // code 5
        vecs.push_back(mk(288, 96, 12'h0F0, 1'b1, 1'b1));   // code 6
        vecs.push_back(mk(288, 160, 12'hA0F, 1'b1, 1'b1));  // code 3
        vecs.push_back(mk(384, 240, 12'h888, 1'b1, 1'b1));  // code 12
        vecs.push_back(mk(384, 384, 12'hFF0, 1'b1, 1'b1));  // code 2, bottom-right cell
        vecs.push_back(mk(398, 398, 12'hFF0, 1'b1, 1'b1));
        vecs.push_back(mk(399, 398, 12'h000, 1'b1, 1'b1));  // gap
        vecs.push_back(mk(239, 80, 12'hFFF, 1'b1, 1'b1));   // border
        vecs.push_back(mk(236, 76, 12'hFFF, 1'b1, 1'b1));   // border corner
        vecs.push_back(mk(403, 403, 12'hFFF, 1'b1, 1'b1));
        vecs.push_back(mk(400, 200, 12'hFFF, 1'b1, 1'b1));
        vecs.push_back(mk(235, 80, 12'h000, 1'b1, 1'b1));   // just outside border
        vecs.push_back(mk(404, 80, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(240, 404, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(240, 56, 12'hFFF, 1'b1, 1'b1));   // bit 15 set
        vecs.push_back(mk(390, 56, 12'hFFF, 1'b1, 1'b1));   // k=15, bit 0 set
        vecs.push_back(mk(250, 56, 12'h333, 1'b1, 1'b1));   // bit 14 clear
        vecs.push_back(mk(248, 56, 12'h000, 1'b1, 1'b1));   // gap between squares
        vecs.push_back(mk(399, 56, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(240, 63, 12'hFFF, 1'b1, 1'b1));
        vecs.push_back(mk(240, 64, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(240, 55, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(0, 0, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(640, 100, 12'h000, 1'b1, 1'b1));  // front porch
        vecs.push_back(mk(656, 100, 12'h000, 1'b0, 1'b1));  // hsync start
        vecs.push_back(mk(751, 100, 12'h000, 1'b0, 1'b1));
        vecs.push_back(mk(752, 100, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(100, 489, 12'h000, 1'b1, 1'b1));
        vecs.push_back(mk(100, 490, 12'h000, 1'b1, 1'b0));  // vsync lines
        vecs.push_back(mk(100, 491, 12'h000, 1'b1, 1'b0));
        vecs.push_back(mk(100, 492, 12'h000, 1'b1, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            render(vecs[i].h, vecs[i].v, rgb, hs, vs);
            check($sformatf("vec%0d(%0d,%0d)_rgb", i, vecs[i].h, vecs[i].v),
                  int'(rgb), int'(vecs[i].rgb));
            check($sformatf("vec%0d_hs", i), int'(hs), int'(vecs[i].hs));
            check($sformatf("vec%0d_vs", i), int'(vs), int'(vecs[i].vs));
        end

        // Input changes between snapshots are invisible until the next snapshot
        grid[19][9] = 4'd5;
        check_pix("stale_cell", 384, 384, 12'hFF0);
        do_snapshot();
        check_pix("fresh_cell", 384, 384, 12'h00F);

        // Changes on the frame_start cycle are captured; one cycle later they are not
        jump(0, 480);
        repeat (3) @(posedge gm_clk);
        @(negedge gm_clk);
        check("fs_edge_high", int'(frame_start), 1);
        grid[19][9] = 4'd6;
        score       = 16'h4000;
        @(posedge gm_clk);
        @(negedge gm_clk);
        grid[19][9] = 4'd7;
        score       = 16'hFFFF;
        check_pix("fs_cycle_cell", 384, 384, 12'h0F0);
        check_pix("fs_cycle_bit15", 240, 56, 12'h333);
        check_pix("fs_cycle_bit14", 250, 56, 12'hFFF);

        // Natural frame_start arrival: (790,479) reaches (0,480) after 10 pixels
        jump(790, 479);
        k = 0;
        while (k < 100) begin
            @(posedge gm_clk);
            k++;
            @(negedge gm_clk);
            if (frame_start) break;
        end
        check("fs_arrival_cycles", k, 43);
        @(posedge gm_clk);
        @(negedge gm_clk);
        check("fs_width", int'(frame_start), 0);

        // vsync: low 12 cycles after reaching (799,489), held for 2 lines
        jump(799, 489);
        k = 0;
        while (k < 100) begin
            @(posedge gm_clk);
            k++;
            @(negedge gm_clk);
            if (!vga_vs) break;
        end
        check("vs_fall_cycles", k, 12);
        k = 1;
        while (k < 8000) begin
            @(posedge gm_clk);
            @(negedge gm_clk);
            if (vga_vs) break;
            k++;
        end
        check("vs_low_cycles", k, 6400);

        // Reset mid-frame with a non-empty shadow
        jump(0, 300);
        repeat (20) @(posedge gm_clk);
        @(negedge gm_clk);
        gm_rst = 1'b1;
        @(posedge gm_clk);
        @(negedge gm_clk);
        check_reset_outputs("midrst");
        repeat (2) @(posedge gm_clk);
        @(negedge gm_clk);
        check_reset_outputs("midrst_hold");
        gm_rst = 1'b0;

        // hsync falls (656+2)*4 cycles after the last reset edge, low 384, high 2816
        k = 0;
        while (k < 4000) begin
            @(posedge gm_clk);
            k++;
            @(negedge gm_clk);
            if (!vga_hs) break;
        end
        check("hs_fall_after_reset", k, 2632);
        k = 1;
        while (k < 1000) begin
            @(posedge gm_clk);
            @(negedge gm_clk);
            if (vga_hs) break;
            k++;
        end
        check("hs_low_cycles", k, 384);
        k = 1;
        while (k < 4000) begin
            @(posedge gm_clk);
            @(negedge gm_clk);
            if (!vga_hs) break;
            k++;
        end
        check("hs_high_cycles", k, 2816);

        // Shadow was cleared: playfield empty despite live grid, border still drawn
        check_pix("post_rst_cell", 240, 80, 12'h000);
        check_pix("post_rst_cell2", 384, 384, 12'h000);
        check_pix("post_rst_bar", 240, 56, 12'h333);
        check_pix("post_rst_border", 239, 80, 12'hFFF);
        do_snapshot();
        check_pix("post_snap_cell", 240, 80, 12'hF00);
        check_pix("post_snap_cell2", 384, 384, 12'hF00);
        check_pix("post_snap_bar", 240, 56, 12'hFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
